// File: rtl/uart_flash_loader.sv
// UART-to-flash loader: parses framed load packets, buffers payload words in a
// small FIFO, writes them to a flash bus slave and answers with one status byte.
module uart_flash_loader #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_select_o,
  output logic              bus_we_o,
  input  logic              bus_ack_i,
  output logic              busy,
  output logic [15:0]       words_done,
  output logic              err_csum,
  output logic              err_ovf,
  output logic              err_timeout,
  output logic [2:0]        dbg_state_o
);
  localparam int BYTES  = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int AW_USE = (ADDR_W < 32) ? ADDR_W : 32;
  localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       addr_sh_q, addr_sh_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        sum_q, sum_d, csum_q, csum_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_csum_q, err_csum_d, err_ovf_q, err_ovf_d, err_to_q, err_to_d;
  logic              load_addr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              sel_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] bus_data_q;
  logic [15:0]       words_done_q;

  logic in_frame, timeout_hit, start, full, empty;
  logic push, drop, push_ok, pop, issue;

  assign in_frame    = state_q inside {S_ADDR, S_LEN, S_DATA, S_CSUM};
  assign timeout_hit = in_frame && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign start       = (state_q == S_IDLE) && rx_valid && (rx_data == 8'hA5);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign push        = (state_q == S_DATA) && rx_valid && (idx_q == LAST_BYTE);
  assign pop         = sel_q && bus_ack_i && !empty;
  assign drop        = push && full && !pop;
  assign push_ok     = push && !drop;
  // The in-flight word lives in bus_data_q, so a timeout flush never disturbs it.
  assign issue       = !sel_q && !empty && !timeout_hit;

  assign to_cnt_d = (!in_frame || rx_valid) ? '0 : to_cnt_q + TO_W'(1);

  // tx handshake: tx_valid rises in RESP and holds with stable tx_data until the
  // cycle tx_ready is also high; that cycle completes the transfer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_sh_d    = addr_sh_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    sum_d        = sum_q;
    csum_d       = csum_q;
    err_csum_d   = err_csum_q;
    err_ovf_d    = err_ovf_q | drop;
    err_to_d     = err_to_q;
    load_addr    = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_ADDR;
        idx_d      = 3'd0;
        sum_d      = 8'h00;
        err_csum_d = 1'b0;
        err_ovf_d  = 1'b0;
        err_to_d   = 1'b0;
      end
      S_ADDR: if (rx_valid) begin
        addr_sh_d = {rx_data, addr_sh_q[31:8]};
        idx_d     = idx_q + 3'd1;
        if (idx_q == 3'd3) begin
          load_addr = 1'b1;
          idx_d     = 3'd0;
          state_d   = S_LEN;
        end
      end
      S_LEN: if (rx_valid) begin
        len_d = {rx_data, len_q[15:8]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd1) begin
          idx_d        = 3'd0;
          words_left_d = len_d;
          state_d      = (len_d == 16'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: if (rx_valid) begin
        for (int b = 0; b < BYTES; b++) begin
          if (idx_q == 3'(b)) word_d[8*b +: 8] = rx_data;
        end
        sum_d = sum_q + rx_data;
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_BYTE) begin
          idx_d        = 3'd0;
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: if (rx_valid) begin
        csum_d  = rx_data;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (empty && !sel_q) begin
        if (!err_to_q && (csum_q != sum_q)) err_csum_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        if (err_to_q)                    tx_data = 8'h54;
        else if (err_csum_q || err_ovf_q) tx_data = 8'h45;
        else                             tx_data = 8'h4B;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) begin
      err_to_d = 1'b1;
      state_d  = S_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      addr_sh_q    <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      csum_q       <= '0;
      to_cnt_q     <= '0;
      err_csum_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_sh_q    <= addr_sh_d;
      len_q        <= len_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      sum_q        <= sum_d;
      csum_q       <= csum_d;
      to_cnt_q     <= to_cnt_d;
      err_csum_q   <= err_csum_d;
      err_ovf_q    <= err_ovf_d;
      err_to_q     <= err_to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !timeout_hit) mem[wr_ptr_q] <= word_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= 1'b0;
      wr_addr_q    <= '0;
      bus_data_q   <= '0;
      words_done_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      if (load_addr) wr_addr_q <= ADDR_W'(addr_sh_d[AW_USE-1:0]);
      if (start) words_done_q <= '0;
      if (issue) begin
        sel_q      <= 1'b1;
        bus_data_q <= mem[rd_ptr_q];
      end else if (sel_q && bus_ack_i) begin
        sel_q        <= 1'b0;
        wr_addr_q    <= wr_addr_q + ADDR_W'(ADDR_STEP);
        words_done_q <= words_done_q + 16'd1;
      end
      if (timeout_hit) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
        else if (!push_ok && pop) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign bus_addr_o   = wr_addr_q;
  assign bus_data_o   = bus_data_q;
  assign bus_select_o = sel_q;
  assign bus_we_o     = sel_q;
  assign busy         = (state_q != S_IDLE) || !empty || sel_q;
  assign words_done   = words_done_q;
  assign err_csum     = err_csum_q;
  assign err_ovf      = err_ovf_q;
  assign err_timeout  = err_to_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_uart_flash_loader.sv
// Bench for uart_flash_loader: builds frames from word lists, models the expected
// bus writes and status byte, and plays a flash slave with configurable ack delay.
module tb_uart_flash_loader;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_select_o;
  logic              bus_we_o;
  logic              bus_ack_i;
  logic              busy;
  logic [15:0]       words_done;
  logic              err_csum;
  logic              err_ovf;
  logic              err_timeout;
  logic [2:0]        dbg_state;

  uart_flash_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_STEP(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_select_o(bus_select_o), .bus_we_o(bus_we_o), .bus_ack_i(bus_ack_i),
    .busy(busy), .words_done(words_done),
    .err_csum(err_csum), .err_ovf(err_ovf), .err_timeout(err_timeout),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  logic [15:0] words_q[$];
  logic [7:0]  fb[$];
  int          ack_delay = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash slave: acks ack_delay cycles after select, checks the request stays put.
  initial begin : slave
    int wait_cnt;
    logic [47:0] held;
    wait_cnt  = 0;
    held      = '0;
    bus_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      if (rst || !bus_select_o) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) held = {bus_addr_o, bus_data_o};
        else check("bus_hold", {bus_addr_o, bus_data_o}, held);
        if (wait_cnt >= ack_delay) begin
          check("bus_we", bus_we_o, 1);
          bus_ack_i = 1'b1;
          obs_q.push_back({bus_addr_o, bus_data_o});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int first, input int last, input int gmin, input int gmax);
    for (int i = first; i < last; i++) send_byte(fb[i], int'($urandom_range(gmax, gmin)));
  endtask

  // Frame bytes and expected writes come straight from the word list and start address.
  task automatic build_frame(input logic [31:0] addr, input logic [7:0] csum_xor);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [15:0] w16;
    sum = 8'h00;
    n   = 16'(words_q.size());
    fb.delete();
    exp_q.delete();
    fb.push_back(8'hA5);
    for (int i = 0; i < 4; i++) fb.push_back(addr[8*i +: 8]);
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    for (int w = 0; w < words_q.size(); w++) begin
      w16 = words_q[w];
      fb.push_back(w16[7:0]);
      fb.push_back(w16[15:8]);
      sum = sum + w16[7:0] + w16[15:8];
      exp_q.push_back({addr + 32'(w), w16});
    end
    fb.push_back(sum ^ csum_xor);
  endtask

  task automatic get_resp(input string tag, output logic [7:0] b);
    int n;
    int hold;
    n = 0;
    b = 8'h00;
    @(negedge clk);
    while (!tx_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_resp_seen"}, tx_valid, 1);
    if (tx_valid) begin
      hold = int'($urandom_range(3, 1));
      for (int i = 0; i < hold; i++) begin
        rx_data  = 8'hA5;
        rx_valid = (i == 0);
        @(negedge clk);
      end
      rx_valid = 1'b0;
      check({tag, "_tx_hold"}, tx_valid, 1);
      b = tx_data;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check({tag, "_tx_done"}, tx_valid, 0);
      check({tag, "_idle"}, busy, 0);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [31:0] addr, input logic [7:0] csum_xor,
                           input int gmin, input int gmax, input logic [7:0] exp_resp);
    logic [7:0] r;
    int nw;
    build_frame(addr, csum_xor);
    nw = exp_q.size();
    send_range(0, fb.size(), gmin, gmax);
    get_resp(tag, r);
    check({tag, "_resp"}, r, exp_resp);
    check({tag, "_err_csum"}, err_csum, (csum_xor != 8'h00));
    check({tag, "_err_ovf"}, err_ovf, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_words_done"}, words_done, nw);
    compare_writes(tag);
  endtask

  initial begin : main
    logic [7:0] r;
    int n;
    int j;
    int nobs;
    logic seen;
    logic [47:0] o;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_select", bus_select_o, 0);
    check("rst_we", bus_we_o, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_data", bus_data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_words_done", words_done, 0);
    check("rst_errs", {err_csum, err_ovf, err_timeout}, 0);

    // Reference frame and its corrupted-checksum twin.
    ack_delay = 0;
    words_q = '{16'h1234, 16'h5678};
    run_frame("basic", 32'h0000_1000, 8'h00, 0, 2, 8'h4B);
    ack_delay = 2;
    words_q = '{16'h1234, 16'h5678};
    run_frame("bad_csum", 32'h0000_1000, 8'h01, 0, 2, 8'h45);

    // Empty frames and address wrap.
    words_q.delete();
    run_frame("n0_ok", 32'h0000_4000, 8'h00, 0, 1, 8'h4B);
    words_q.delete();
    run_frame("n0_bad", 32'h0000_4000, 8'h01, 0, 1, 8'h45);
    words_q = '{16'hBEEF, 16'hCAFE};
    run_frame("wrap", 32'hFFFF_FFFF, 8'h00, 0, 1, 8'h4B);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      logic bad;
      logic [7:0] x;
      ack_delay = int'($urandom_range(4, 0));
      words_q.delete();
      n = int'($urandom_range(5, 1));
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      bad = ($urandom_range(3, 0) == 0);
      x = bad ? 8'($urandom_range(255, 1)) : 8'h00;
      run_frame($sformatf("rand%0d", f), $urandom, x, 0, 3, bad ? 8'h45 : 8'h4B);
    end

    // Slow slave: 12 words at one byte every 4 cycles must overflow the FIFO.
    ack_delay = 50;
    words_q.delete();
    for (int i = 0; i < 12; i++) words_q.push_back(16'($urandom));
    build_frame(32'h0000_3000, 8'h00);
    send_range(0, fb.size(), 3, 3);
    get_resp("ovf", r);
    check("ovf_resp", r, 8'h45);
    check("ovf_err_ovf", err_ovf, 1);
    check("ovf_err_csum", err_csum, 0);
    nobs = obs_q.size();
    check("ovf_some_dropped", (nobs < 12), 1);
    check("ovf_words_done", words_done, nobs);
    j = 0;
    for (int i = 0; i < nobs; i++) begin
      o = obs_q[i];
      check("ovf_addr", o[47:16], 32'h0000_3000 + 32'(i));
      if (i < DEPTH) begin
        check("ovf_head_data", o[15:0], words_q[i]);
        j = i + 1;
      end else begin
        while (j < words_q.size() && words_q[j] != o[15:0]) j++;
        check("ovf_in_order", (j < words_q.size()), 1);
        j++;
      end
    end
    obs_q.delete();
    exp_q.delete();

    // Same load with a fast slave fits.
    ack_delay = 0;
    run_frame("fast", 32'h0000_3000, 8'h00, 3, 3, 8'h4B);

    // Inter-byte timeout with a write still in flight.
    ack_delay = 150;
    words_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    build_frame(32'h0000_2000, 8'h00);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    send_range(0, 9, 0, 2);
    send_byte(fb[9], 0);
    n = 0;
    while (!err_timeout && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_cycles", n, TIMEOUT);
    check("to_inflight", bus_select_o, 1);
    get_resp("to", r);
    check("to_resp", r, 8'h54);
    check("to_flag", err_timeout, 1);
    check("to_words_done", words_done, 1);
    compare_writes("to");
    send_byte(8'hA5, 0);
    check("to_clear_flag", err_timeout, 0);
    check("to_clear_words", words_done, 0);
    ack_delay = 1;
    words_q = '{16'h0F0F, 16'hF0F0};
    build_frame(32'h0000_5000, 8'h00);
    send_range(1, fb.size(), 0, 2);
    get_resp("after_to", r);
    check("after_to_resp", r, 8'h4B);
    compare_writes("after_to");

    // Reset while a write is outstanding.
    ack_delay = 200;
    words_q = '{16'hAAAA, 16'h5555};
    build_frame(32'h0000_6000, 8'h00);
    send_range(0, 9, 0, 1);
    n = 0;
    while (!bus_select_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_select_seen", bus_select_o, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_select", bus_select_o, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_words", words_done, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || bus_select_o) seen = 1'b1;
    end
    check("rst_mid_quiet", seen, 0);
    check("rst_mid_no_write", obs_q.size(), 0);
    obs_q.delete();
    exp_q.delete();

    // Junk before the header is discarded.
    ack_delay = 0;
    send_byte(8'h00, 0);
    send_byte(8'h5A, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h4B, 0);
    check("junk_idle", busy, 0);
    words_q = '{16'h0102, 16'h0304, 16'h0506};
    run_frame("junk_then_frame", 32'h0000_7000, 8'h00, 0, 2, 8'h4B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
